// File: rtl/fetch_queue_unit_if.sv
// Bus bundle between the fetch queue and its icache/predictor/ROB/decode neighbours.
// The slave modport is the fetch_queue_unit view; master is the surrounding pipeline.
interface fetch_queue_unit_if;
    logic        fetchValid;
    logic [31:0] fetchAddr;
    logic        instrInValid;
    logic [31:0] instrIn;
    logic [31:0] instrAddr;
    logic        jump;
    logic        flush;
    logic [31:0] flushAddr;
    logic        jalrDone;
    logic [31:0] jalrTarget;
    logic        issueValid;
    logic [31:0] issueInstr;
    logic [31:0] issuePc;
    logic        issuePredTaken;
    logic        issueReady;

    modport slave (
        output fetchValid, fetchAddr,
        input  instrInValid, instrIn, instrAddr, jump,
        input  flush, flushAddr, jalrDone, jalrTarget,
        output issueValid, issueInstr, issuePc, issuePredTaken,
        input  issueReady
    );

    modport master (
        input  fetchValid, fetchAddr,
        output instrInValid, instrIn, instrAddr, jump,
        output flush, flushAddr, jalrDone, jalrTarget,
        input  issueValid, issueInstr, issuePc, issuePredTaken,
        output issueReady
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, pre-decodes branch/JAL/JALR and buffers fetched words in a circular queue.
// Optional macro FETCH_JAL_REDIRECT_EN: JAL target computed in fetch; otherwise JAL stalls like JALR.
module fetch_queue_unit #(
    parameter int unsigned QUEUE_DEPTH_LOG2 = 3,
    parameter logic [31:0] RESET_PC         = 32'h0
) (
    input  logic              clockIn,
    input  logic              resetIn,
    fetch_queue_unit_if.slave bus
);
    localparam int unsigned IDX_W = QUEUE_DEPTH_LOG2;
    localparam int unsigned PTR_W = QUEUE_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << QUEUE_DEPTH_LOG2;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [31:0]      r_pc;
    logic             r_stall;

    logic        w_full;
    logic        w_empty;
    logic        w_fetch_valid;
    logic        w_accept;
    logic        w_pop;
    logic [31:0] w_next_pc;
    logic        w_set_stall;
    logic        w_pred;
    logic [31:0] w_bimm;
`ifdef FETCH_JAL_REDIRECT_EN
    logic [31:0] w_jimm;
`endif
    entry_t      w_head_entry;

    assign w_full  = (r_head[IDX_W] != r_tail[IDX_W]) && (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]);
    assign w_empty = (r_head == r_tail);

    assign w_fetch_valid = ~r_stall & ~w_full;
    // Mismatched instrAddr marks a stale response from before a redirect; it is dropped.
    assign w_accept = w_fetch_valid & bus.instrInValid & (bus.instrAddr == r_pc) & ~bus.flush;
    assign w_pop    = ~w_empty & bus.issueReady & ~bus.flush;

    assign w_bimm = {{20{bus.instrIn[31]}}, bus.instrIn[7], bus.instrIn[30:25],
                     bus.instrIn[11:8], 1'b0};
`ifdef FETCH_JAL_REDIRECT_EN
    assign w_jimm = {{12{bus.instrIn[31]}}, bus.instrIn[19:12], bus.instrIn[20],
                     bus.instrIn[30:21], 1'b0};
`endif

    // Next-PC selection from the pre-decoded opcode of the accepted word.
    always_comb begin
        w_next_pc   = r_pc + 32'd4;
        w_set_stall = 1'b0;
        w_pred      = 1'b0;
        case (bus.instrIn[6:0])
            OP_BRANCH: begin
                w_pred = bus.jump;
                if (bus.jump) begin
                    w_next_pc = r_pc + w_bimm;
                end
            end
            OP_JAL: begin
`ifdef FETCH_JAL_REDIRECT_EN
                w_next_pc = r_pc + w_jimm;
`else
                w_next_pc   = r_pc;
                w_set_stall = 1'b1;
`endif
            end
            OP_JALR: begin
                w_next_pc   = r_pc;
                w_set_stall = 1'b1;
            end
            default: ;
        endcase
    end

    // Control state: reset beats flush, flush beats accept/pop/jalrDone.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_pc    <= RESET_PC;
            r_stall <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (bus.flush) begin
            r_pc    <= bus.flushAddr;
            r_stall <= 1'b0;
            r_head  <= r_tail;
        end else begin
            if (w_accept) begin
                r_pc    <= w_next_pc;
                r_stall <= w_set_stall;
                r_tail  <= r_tail + PTR_W'(1);
            end else if (r_stall && bus.jalrDone) begin
                r_pc    <= bus.jalrTarget;
                r_stall <= 1'b0;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

    // Queue storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clockIn) begin
        if (w_accept) begin
            r_mem[r_tail[IDX_W-1:0]] <= '{instr: bus.instrIn, pc: r_pc, pred: w_pred};
        end
    end

    assign w_head_entry = r_mem[r_head[IDX_W-1:0]];

    assign bus.fetchValid     = w_fetch_valid;
    assign bus.fetchAddr      = r_pc;
    assign bus.issueValid     = ~w_empty;
    assign bus.issueInstr     = w_head_entry.instr;
    assign bus.issuePc        = w_head_entry.pc;
    assign bus.issuePredTaken = w_head_entry.pred;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: directed icache responses push expected issue
// entries; a negedge monitor pops and compares every handshake on the issue port.
module tb_fetch_queue_unit;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] JAL  = 32'h0100006F;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    fetch_queue_unit_if bus ();

    fetch_queue_unit #(
        .QUEUE_DEPTH_LOG2(DEPTH_LOG2),
        .RESET_PC        (32'h0)
    ) dut (
        .clockIn(clk),
        .resetIn(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.issueValid === 1'b1 && bus.issueReady && !bus.flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL issue_unexpected: got pc %h with no entry expected", bus.issuePc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_instr", bus.issueInstr, e.instr);
                check("issue_pc", bus.issuePc, e.pc);
                check("issue_pred", 32'(bus.issuePredTaken), 32'(e.pred));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.issueReady = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_flush(input logic [31:0] addr);
        bus.flush     = 1'b1;
        bus.flushAddr = addr;
        step();
        bus.flush = 1'b0;
        exp_q.delete();
        check("flush_issue_valid", 32'(bus.issueValid), 32'd0);
        check("flush_fetch_addr", bus.fetchAddr, addr);
        check("flush_fetch_valid", 32'(bus.fetchValid), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input logic jmp,
                         input logic exp_pred, input logic [31:0] exp_next, input logic exp_fv);
        exp_t e;
        check("pre_fetch_valid", 32'(bus.fetchValid), 32'd1);
        check("pre_fetch_addr", bus.fetchAddr, addr);
        bus.instrInValid = 1'b1;
        bus.instrAddr    = addr;
        bus.instrIn      = instr;
        bus.jump         = jmp;
        e.instr = instr;
        e.pc    = addr;
        e.pred  = exp_pred;
        exp_q.push_back(e);
        step();
        bus.instrInValid = 1'b0;
        bus.jump         = 1'b0;
        check("next_fetch_addr", bus.fetchAddr, exp_next);
        check("next_fetch_valid", 32'(bus.fetchValid), 32'(exp_fv));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst               = 1'b1;
        bus.instrInValid  = 1'b0;
        bus.instrIn       = '0;
        bus.instrAddr     = '0;
        bus.jump          = 1'b0;
        bus.flush         = 1'b0;
        bus.flushAddr     = '0;
        bus.jalrDone      = 1'b0;
        bus.jalrTarget    = '0;
        bus.issueReady    = 1'b0;

        do_reset();
        check("reset_fetch_valid", 32'(bus.fetchValid), 32'd1);
        check("reset_fetch_addr", bus.fetchAddr, 32'h0);
        check("reset_issue_valid", 32'(bus.issueValid), 32'd0);

        // Straight-line stream at full rate
        bus.issueReady = 1'b1;
        fetch(32'h0, ADDI, 1'b0, 1'b0, 32'h4, 1'b1);
        check("first_issue_valid", 32'(bus.issueValid), 32'd1);
        fetch(32'h4, ADDI, 1'b0, 1'b0, 32'h8, 1'b1);
        fetch(32'h8, ADDI, 1'b0, 1'b0, 32'hC, 1'b1);
        wait_drain();

        // Branch taken / not taken
        do_flush(32'h100);
        fetch(32'h100, 32'h00000863, 1'b1, 1'b1, 32'h110, 1'b1);
        wait_drain();
        do_flush(32'h100);
        fetch(32'h100, 32'h00000863, 1'b0, 1'b0, 32'h104, 1'b1);
        wait_drain();

        // JAL: predictor bit must not be recorded for non-branches
        do_flush(32'h20);
`ifdef FETCH_JAL_REDIRECT_EN
        fetch(32'h20, JAL, 1'b1, 1'b0, 32'h30, 1'b1);
`else
        fetch(32'h20, JAL, 1'b1, 1'b0, 32'h20, 1'b0);
        bus.jalrDone   = 1'b1;
        bus.jalrTarget = 32'h30;
        step();
        bus.jalrDone = 1'b0;
        check("jal_resolve_addr", bus.fetchAddr, 32'h30);
        check("jal_resolve_valid", 32'(bus.fetchValid), 32'd1);
`endif
        wait_drain();

        // JALR stall then resolve
        do_flush(32'h40);
        fetch(32'h40, JALR, 1'b0, 1'b0, 32'h40, 1'b0);
        step();
        check("jalr_still_stalled", 32'(bus.fetchValid), 32'd0);
        bus.jalrDone   = 1'b1;
        bus.jalrTarget = 32'h200;
        step();
        bus.jalrDone = 1'b0;
        check("jalr_target_addr", bus.fetchAddr, 32'h200);
        check("jalr_target_valid", 32'(bus.fetchValid), 32'd1);
        bus.jalrDone   = 1'b1;
        bus.jalrTarget = 32'h999;
        step();
        bus.jalrDone = 1'b0;
        check("jalrdone_ignored", bus.fetchAddr, 32'h200);
        bus.instrInValid = 1'b1;
        bus.instrAddr    = 32'h204;
        bus.instrIn      = ADDI;
        step();
        bus.instrInValid = 1'b0;
        check("stale_addr", bus.fetchAddr, 32'h200);
        check("stale_no_entry", 32'(bus.issueValid), 32'd0);
        wait_drain();

        // Back-pressure with a 4-entry queue
        bus.issueReady = 1'b0;
        do_flush(32'h300);
        fetch(32'h300, ADDI, 1'b0, 1'b0, 32'h304, 1'b1);
        fetch(32'h304, ADDI, 1'b0, 1'b0, 32'h308, 1'b1);
        fetch(32'h308, ADDI, 1'b0, 1'b0, 32'h30C, 1'b1);
        fetch(32'h30C, ADDI, 1'b0, 1'b0, 32'h310, 1'b0);
        bus.instrInValid = 1'b1;
        bus.instrAddr    = 32'h310;
        bus.instrIn      = ADDI;
        step();
        bus.instrInValid = 1'b0;
        check("full_blocks_addr", bus.fetchAddr, 32'h310);
        check("full_blocks_valid", 32'(bus.fetchValid), 32'd0);
        bus.issueReady = 1'b1;
        step();
        bus.issueReady = 1'b0;
        check("pop_reenables", 32'(bus.fetchValid), 32'd1);
        fetch(32'h310, ADDI, 1'b0, 1'b0, 32'h314, 1'b0);
        bus.issueReady = 1'b1;
        wait_drain();

        // Flush colliding with jalrDone and a valid response while stalled, 3 entries queued
        bus.issueReady = 1'b0;
        do_flush(32'h400);
        fetch(32'h400, ADDI, 1'b0, 1'b0, 32'h404, 1'b1);
        fetch(32'h404, ADDI, 1'b0, 1'b0, 32'h408, 1'b1);
        fetch(32'h408, JALR, 1'b0, 1'b0, 32'h408, 1'b0);
        bus.flush        = 1'b1;
        bus.flushAddr    = 32'h80;
        bus.jalrDone     = 1'b1;
        bus.jalrTarget   = 32'h500;
        bus.instrInValid = 1'b1;
        bus.instrAddr    = 32'h408;
        bus.instrIn      = ADDI;
        bus.issueReady   = 1'b1;
        step();
        bus.flush        = 1'b0;
        bus.jalrDone     = 1'b0;
        bus.instrAddr    = 32'h84;
        exp_q.delete();
        check("collide_issue_valid", 32'(bus.issueValid), 32'd0);
        check("collide_fetch_addr", bus.fetchAddr, 32'h80);
        check("collide_fetch_valid", 32'(bus.fetchValid), 32'd1);
        step();
        bus.instrInValid = 1'b0;
        check("collide_stale_addr", bus.fetchAddr, 32'h80);
        check("collide_stale_empty", 32'(bus.issueValid), 32'd0);
        fetch(32'h80, ADDI, 1'b0, 1'b0, 32'h84, 1'b1);
        wait_drain();

        // PC wrap-around on a taken branch
        do_flush(32'hFFFFFFF0);
        fetch(32'hFFFFFFF0, 32'h02000063, 1'b1, 1'b1, 32'h10, 1'b1);
        wait_drain();

        // Reset mid-operation discards entries and the JALR stall
        bus.issueReady = 1'b0;
        do_flush(32'h600);
        fetch(32'h600, ADDI, 1'b0, 1'b0, 32'h604, 1'b1);
        fetch(32'h604, JALR, 1'b0, 1'b0, 32'h604, 1'b0);
        do_reset();
        check("rst2_fetch_valid", 32'(bus.fetchValid), 32'd1);
        check("rst2_fetch_addr", bus.fetchAddr, 32'h0);
        check("rst2_issue_valid", 32'(bus.issueValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised successor of the front-end fetch stage: owns the PC, requests instructions from the icache, pre-decodes control flow (branch, JAL, JALR), and buffers fetched instructions with their PC and prediction bit in a circular queue. The queue drains to decode/issue through a valid/ready handshake, decoupling fetch from RS/ROB/LSB back-pressure. It sits between the icache and predictor on one side and decode/issue and the reorder buffer on the other. The ROB can redirect it with a flush.

## Interface
- `QUEUE_DEPTH_LOG2`, 3: queue holds 2^N entries (N ≥ 1).
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `clockIn` in 1: the single clock; all state updates on its rising edge.
- `resetIn` in 1: synchronous, active-high reset.
- `fetchValid` out 1: fetch request valid (icache).
- `fetchAddr` out 32: address to fetch; equals the PC.
- `instrInValid` in 1: icache response valid.
- `instrIn` in 32: icache instruction word.
- `instrAddr` in 32: address the response belongs to.
- `jump` in 1: predictor taken bit for the instruction on `instrIn`.
- `flush` in 1: ROB redirect (mispredict or exception).
- `flushAddr` in 32: redirect target.
- `jalrDone` in 1: ROB resolved the pending JALR.
- `jalrTarget` in 32: resolved JALR target.
- `issueValid` out 1: head entry valid.
- `issueInstr` out 32: head instruction word.
- `issuePc` out 32: head instruction PC.
- `issuePredTaken` out 1: prediction recorded for head (branch only; 0 otherwise).
- `issueReady` in 1: decode/issue accepts head this cycle.

## Operation
- State:
  - PC
  - stall flag
  - queue storage `{instr, pc, predTaken}`
  - head and tail pointers of `QUEUE_DEPTH_LOG2+1` bits each; the MSB is the wrap bit.
- Full/empty:
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
- `fetchValid = ~stall & ~full`.
- Accept: `fetchValid & instrInValid & (instrAddr == PC) & ~flush`.
  - A response with a mismatched address is a stale response and is dropped silently.
- On accept, push `{instrIn, PC, pred}` at the tail and select next PC by opcode `instrIn[6:0]`:
  - `1100011` (branch): PC ← `jump ? PC+Bimm : PC+4`; pred = `jump`.
  - `1101111` (JAL): PC ← `PC+Jimm` (subject to Configuration).
  - `1100111` (JALR): PC unchanged; stall ← 1.
  - Any other opcode: PC ← PC+4.
- Immediate formats:
  - Bimm = `{{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}`.
  - Jimm = `{{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}`.
  - All PC arithmetic is 32-bit modulo 2^32, with wrap-around allowed.
- Pop: when `issueValid & issueReady`, head advances. `issueValid = ~empty`.
- Simultaneous push and pop are both legal. Count is unchanged; the push can only occur when not full.
- When stalled and `jalrDone` is asserted: PC ← `jalrTarget`, stall ← 0.
  - `jalrDone` while not stalled is ignored.
- `flush` has priority over every other event in the same cycle:
  - PC ← `flushAddr`
  - stall ← 0
  - head ← tail (queue emptied)
  - no push, no pop
  - `jalrDone` is ignored
- Reset has priority over flush:
  - PC ← `RESET_PC`, stall ← 0, pointers ← 0.
  - Queue contents are don't-care.
  - Reset asserted mid-operation discards all pending entries and any JALR stall.
- Reset output values:
  - `fetchValid` = 1, `fetchAddr` = `RESET_PC`.
  - `issueValid` = 0; `issueInstr`, `issuePc` and `issuePredTaken` are don't-care.

## Timing
- Accept in cycle N → entry visible at the head (if the queue was empty) with `issueValid` = 1 in N+1. `fetchAddr` shows the next PC in N+1.
- One instruction is accepted per cycle at most; a full-rate stream is sustainable while the queue is not full.
- Queue full in cycle N → `fetchValid` = 0 in N. A pop in N re-enables fetch in N+1.
- JALR accepted in N → `fetchValid` = 0 from N+1. `jalrDone` in M → `fetchAddr` = `jalrTarget` and `fetchValid` = 1 in M+1.
- `flush` in N → in N+1: `issueValid` = 0, `fetchAddr` = `flushAddr`, `fetchValid` = 1. An icache response arriving in N is discarded.
- Output signals are combinational from registered state only. There is no combinational path from `instrIn` or `issueReady` to any output.

## Configuration
- `FETCH_JAL_REDIRECT_EN`:
  - Defined: JAL computes its target in fetch, PC ← PC+Jimm with no stall.
  - Undefined: JAL is handled exactly like JALR. It sets stall, and the next PC comes from `jalrDone`/`jalrTarget`.

## Test plan
- Straight line: reset with `RESET_PC` = 0, icache returns `addi` at 0, 4 and 8 with `issueReady` = 1 → issue sees PCs 0, 4 and 8 on consecutive cycles, and `fetchAddr` reaches 12.
- Branch predicted taken: `instrIn` = 32'h00000863 (`beq`, +16) at PC 0x100 with `jump` = 1 → next `fetchAddr` = 0x110 and `issuePredTaken` = 1. With `jump` = 0 → next `fetchAddr` = 0x104 and `issuePredTaken` = 0.
- JAL/JALR:
  - 32'h0100006F (`jal` +16) at 0x20 → next `fetchAddr` = 0x30 with the macro defined; stall with it undefined.
  - `jalr` at 0x40 → `fetchValid` = 0 until `jalrDone` with `jalrTarget` = 0x200, then `fetchAddr` = 0x200 on the next cycle.
- Back-pressure: with `QUEUE_DEPTH_LOG2` = 2, hold `issueReady` = 0 → exactly 4 entries are accepted, then `fetchValid` = 0. One pop re-enables exactly one further fetch, and entries drain in order.
- Flush collision: with 3 entries queued and the unit stalled on a JALR, assert `flush` (`flushAddr` = 0x80), `jalrDone` and a valid icache response in the same cycle → next cycle the queue is empty, stall is cleared and `fetchAddr` = 0x80. Stale responses with `instrAddr` ≠ 0x80 are ignored.
- PC wrap: branch at 0xFFFFFFF0 with +32 taken → `fetchAddr` = 0x00000010.
